// File: rtl/apb_req_master_pkg.sv
// rtl/apb_req_master_pkg.sv - shared types and constants for the APB request master
package apb_req_master_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // A disabled timeout (0) still needs a legal 1-bit vector for the tie-off.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - saturating ACCESS-phase wait counter with expiry flag
module apb_timeout_cnt
  import apb_req_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk_i, rst_i, clr_i, en_i};
      assign expired_o     = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired_o = (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - single-outstanding APB3 initiator with PREADY timeout
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  output logic [3:0]            DECODE4BIT,
  input  logic                  PREADY,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PSLVERR
);

  state_e                state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic                  tmo_clr, tmo_en, tmo_expired;

  assign tmo_clr = (state_q == IDLE) && req_valid;
  assign tmo_en  = (state_q == ACCESS) && !PREADY;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = SETUP;
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY takes priority over an expiry in the same cycle.
        if (PREADY) begin
          state_d = RESP;
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
        end else if (tmo_expired) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // Held low while PRESET is asserted so no output is active during reset.
  assign req_ready   = (state_q == IDLE) && !PRESET;
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign DECODE4BIT  = paddr_q[ADDR_WIDTH-1:ADDR_WIDTH-4];
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_req_master.sv
// tb/tb_apb_req_master.sv - scoreboard bench for apb_req_master with a modelled APB slave
module tb_apb_req_master;

  localparam int TMO = 8;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] rdata;
    logic        err;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          cyc;
    int          delay;
  } exp_t;

  logic        PCLK, PRESET;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  DECODE4BIT;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    hs_cyc = 0;
  exp_t  sb_q[$];
  plan_t plan_q[$];

  apb_req_master #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .DECODE4BIT(DECODE4BIT),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required completion", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a response arrives after the setup cycle plus every ACCESS cycle spent.
  function automatic exp_t model(input plan_t p, input int n, input int delay);
    exp_t e;
    if (p.wait_n >= TMO) begin
      e.rdata = 32'd0;
      e.err   = 1'b1;
      e.tmo   = 1'b1;
      e.cyc   = n + 2 + TMO;
    end else begin
      e.rdata = p.wr ? 32'd0 : p.rdata;
      e.err   = p.err;
      e.tmo   = 1'b0;
      e.cyc   = n + 3 + p.wait_n;
    end
    e.delay = delay;
    return e;
  endfunction

  // APB slave: holds PREADY low for wait_n ACCESS cycles and checks address-phase stability.
  initial begin
    plan_t cur;
    int    acc_seen;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    acc_seen = 0;
    cur = '{wr: 1'b0, addr: 16'd0, wdata: 32'd0, wait_n: 0, rdata: 32'd0, err: 1'b0};
    forever begin
      @(negedge PCLK);
      if (PSEL === 1'b1 && PENABLE === 1'b0) begin
        chk("setup_has_request", 32'(plan_q.size() != 0), 32'd1);
        if (plan_q.size() != 0) cur = plan_q.pop_front();
        acc_seen = 0;
        chk("setup_paddr", 32'(PADDR), 32'(cur.addr));
        chk("setup_pwrite", 32'(PWRITE), 32'(cur.wr));
        chk("setup_pwdata", PWDATA, cur.wdata);
        PREADY = 1'(($urandom_range(0, 1)));
        PRDATA = $urandom();
      end else if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        chk("access_paddr", 32'(PADDR), 32'(cur.addr));
        chk("access_pwrite", 32'(PWRITE), 32'(cur.wr));
        chk("access_pwdata", PWDATA, cur.wdata);
        PREADY  = (acc_seen >= cur.wait_n);
        PRDATA  = PREADY ? cur.rdata : $urandom();
        PSLVERR = PREADY ? cur.err : 1'(($urandom_range(0, 1)));
        acc_seen++;
      end else begin
        if (PENABLE === 1'b1) chk("penable_without_psel", 32'(PENABLE), 32'd0);
        PREADY  = 1'(($urandom_range(0, 1)));
        PRDATA  = $urandom();
        PSLVERR = 1'(($urandom_range(0, 1)));
      end
    end
  end

  // Monitor: consumes responses with per-transaction backpressure and checks against the scoreboard.
  initial begin
    exp_t e;
    int   waited;
    logic prev_valid;
    rsp_ready = 1'b0;
    waited = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESET !== 1'b0) begin
        rsp_ready = 1'b0; waited = 0; prev_valid = 1'b0;
        continue;
      end
      if (rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
          rsp_ready = 1'b1;
          prev_valid = 1'b0;
        end else begin
          e = sb_q[0];
          if (!prev_valid) chk("rsp_latency", 32'(cyc), 32'(e.cyc));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          chk("psel_in_resp", 32'({PSEL, PENABLE}), 32'd0);
          if (waited >= e.delay) begin
            rsp_ready = 1'b1;
            void'(sb_q.pop_front());
            hs_cyc = cyc;
            waited = 0;
            prev_valid = 1'b0;
          end else begin
            rsp_ready = 1'b0;
            waited++;
            prev_valid = 1'b1;
          end
        end
      end else begin
        rsp_ready = 1'b0;
        prev_valid = 1'b0;
      end
    end
  end

  task automatic issue(input plan_t p, input int rdelay, input bit expect_rsp, output int n_acc);
    int t;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = p.wr; req_addr = p.addr; req_wdata = p.wdata;
    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin
      @(negedge PCLK);
      t++;
    end
    chk("req_accepted", 32'(req_ready), 32'd1);
    n_acc = cyc;
    if (req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    plan_q.push_back(p);
    if (expect_rsp) sb_q.push_back(model(p, cyc, rdelay));
    @(negedge PCLK);
    req_valid = 1'b0;
    req_write = 1'(($urandom_range(0, 1)));
    req_addr  = 16'($urandom());
    req_wdata = $urandom();
    chk("setup_phase", 32'({PSEL, PENABLE}), 32'd2);
    chk("decode4bit", 32'(DECODE4BIT), 32'(p.addr[15:12]));
    @(negedge PCLK);
    chk("access_phase", 32'({PSEL, PENABLE}), 32'd3);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || rsp_valid === 1'b1) && t < 200) begin
      @(negedge PCLK);
      t++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_psel_penable", 32'({PSEL, PENABLE}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_flags", 32'({rsp_err, rsp_timeout}), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_apb_addr", 32'({PWRITE, DECODE4BIT, PADDR}), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
  endtask

  function automatic plan_t mk(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                               input int w, input logic [31:0] rd, input logic e);
    plan_t p;
    p.wr = wr; p.addr = a; p.wdata = wd; p.wait_n = w; p.rdata = rd; p.err = e;
    return p;
  endfunction

  initial begin
    int n1, n2;
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge PCLK);
    check_reset_outputs();
    PRESET = 1'b0;

    // Zero-wait write, then back-to-back to confirm the 4-cycle peak rate.
    issue(mk(1'b1, 16'h2004, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1'b0), 0, 1'b1, n1);
    issue(mk(1'b0, 16'h2008, 32'h0, 0, 32'h0BADF00D, 1'b0), 0, 1'b1, n2);
    chk("peak_rate", 32'(n2 - n1), 32'd4);
    drain();

    // Wait-state read, slave error, timeout, and PREADY in the expiry cycle.
    issue(mk(1'b0, 16'h1010, 32'h0, 3, 32'h12345678, 1'b0), 0, 1'b1, n1);
    issue(mk(1'b0, 16'h3000, 32'h0, 0, 32'hCAFE0001, 1'b1), 1, 1'b1, n1);
    issue(mk(1'b0, 16'h4000, 32'h0, 100, 32'hFFFFFFFF, 1'b0), 0, 1'b1, n1);
    issue(mk(1'b0, 16'h5000, 32'h0, TMO - 1, 32'h55AA55AA, 1'b0), 0, 1'b1, n1);
    drain();

    // Backpressure with a second request waiting.
    issue(mk(1'b1, 16'h6000, 32'h11112222, 0, 32'h0, 1'b0), 5, 1'b1, n1);
    issue(mk(1'b0, 16'h7004, 32'h0, 1, 32'h33334444, 1'b0), 0, 1'b1, n2);
    chk("accept_after_rsp", 32'(n2), 32'(hs_cyc + 1));
    drain();

    // Reset in the middle of a waited ACCESS phase aborts without a response.
    issue(mk(1'b0, 16'h8000, 32'h0, 20, 32'h0, 1'b0), 0, 1'b0, n1);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    check_reset_outputs();
    PRESET = 1'b0;
    issue(mk(1'b0, 16'h9ABC, 32'h0, 2, 32'h87654321, 1'b0), 0, 1'b1, n1);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(mk(1'(($urandom_range(0, 1))), 16'($urandom()), $urandom(), $urandom_range(0, 10),
               $urandom(), 1'(($urandom_range(0, 1)))), $urandom_range(0, 3), 1'b1, n1);
    end
    drain();
    chk("plan_queue_empty", 32'(plan_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
